// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by the IF/ID register, hazard logic and decode.
package mips_pkg;

   localparam logic [5:0]  OP_RTYPE = 6'h00;
   localparam logic [5:0]  OP_BEQ   = 6'h04;
   localparam logic [5:0]  OP_BNE   = 6'h05;
   localparam logic [5:0]  OP_LW    = 6'h23;
   localparam logic [5:0]  OP_SW    = 6'h2B;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] low;
   } inst_fields_t;

   // Opcodes whose rt field is a source operand rather than a destination.
   function automatic logic uses_rt(input logic [5:0] opcode);
      logic r;
      r = 1'b0;
      case (opcode)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard equation: the instruction in ID reads the register an ID/EX load writes.
module hazard_detect
   import mips_pkg::*;
(
   input  logic       id_valid,
   input  logic [5:0] opcode,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       ex_MemRead,
   input  logic [4:0] ex_Rt,
   output logic       stall
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = (ex_Rt == rs);
   assign rt_hit = uses_rt(opcode) & (ex_Rt == rt);
   // $0 is hardwired to zero, so a load targeting it can never create a dependency.
   assign stall  = id_valid & ex_MemRead & (ex_Rt != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with load-use stall, branch flush and saturating stall/flush counters.
module if_id_pipe
   import mips_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter int               CNT_W = 16,
   parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_WORD)
)(
   input  logic             CLK,
   input  logic             Reset,
   input  logic [WIDTH-1:0] if_Inst,
   input  logic [WIDTH-1:0] if_PC,
   input  logic             if_valid,
   input  logic             flush,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_Rt,
   output logic [WIDTH-1:0] id_Inst,
   output logic [WIDTH-1:0] id_PC,
   output logic             id_valid,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] id_inst_reg;
   logic [WIDTH-1:0] id_pc_reg;
   logic             id_valid_reg;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;
   logic             stall_next;

   hazard_detect u_hazard (
      .id_valid   (id_valid_reg),
      .opcode     (id_inst_reg[31:26]),
      .rs         (id_inst_reg[25:21]),
      .rt         (id_inst_reg[20:16]),
      .ex_MemRead (ex_MemRead),
      .ex_Rt      (ex_Rt),
      .stall      (stall_next)
   );

   // Flush outranks stall: a squashed instruction must not be held.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         id_inst_reg  <= NOP;
         id_pc_reg    <= '0;
         id_valid_reg <= 1'b0;
      end else if (flush) begin
         id_inst_reg  <= NOP;
         id_pc_reg    <= if_PC;
         id_valid_reg <= 1'b0;
      end else if (!stall_next) begin
         id_inst_reg  <= if_valid ? if_Inst : NOP;
         id_pc_reg    <= if_PC;
         id_valid_reg <= if_valid;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_next && !flush && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
         if (flush && (flush_cnt_reg != '1))
            flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
   end

   assign id_Inst   = id_inst_reg;
   assign id_PC     = id_pc_reg;
   assign id_valid  = id_valid_reg;
   assign stall     = stall_next;
   assign bubble    = stall_next;
   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed scoreboard bench for the IF/ID register and load-use hazard unit.
module tb_if_id_pipe;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] if_Inst;
   logic [31:0] if_PC;
   logic        if_valid;
   logic        flush;
   logic        ex_MemRead;
   logic [4:0]  ex_Rt;
   logic [31:0] id_Inst;
   logic [31:0] id_PC;
   logic        id_valid;
   logic        stall;
   logic        bubble;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        valid;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   passed = 0;

   if_id_pipe #(.WIDTH(32), .CNT_W(16), .NOP(32'h0000_0000)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .if_Inst    (if_Inst),
      .if_PC      (if_PC),
      .if_valid   (if_valid),
      .flush      (flush),
      .ex_MemRead (ex_MemRead),
      .ex_Rt      (ex_Rt),
      .id_Inst    (id_Inst),
      .id_PC      (id_PC),
      .id_valid   (id_valid),
      .stall      (stall),
      .bubble     (bubble),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v);
      if_Inst  = inst;
      if_PC    = pc;
      if_valid = v;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic v);
      exp_t e;
      e.inst  = inst;
      e.pc    = pc;
      e.valid = v;
      exp_q.push_back(e);
   endtask

   // One clock; compare the oldest scoreboard entry against the registered outputs.
   task automatic tick();
      exp_t e;
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("id_Inst", id_Inst, e.inst);
         check("id_PC", id_PC, e.pc);
         check("id_valid", 32'(id_valid), 32'(e.valid));
         $display("txn inst=%h pc=%h valid=%0b stall=%0b", id_Inst, id_PC, id_valid, stall);
      end
   endtask

   initial begin
      Reset = 1'b1;
      flush = 1'b0;
      ex_MemRead = 1'b0;
      ex_Rt = 5'd0;
      drive(32'h0, 32'h0, 1'b0);
      #12;
      check("rst_inst", id_Inst, 32'h0);
      check("rst_pc", id_PC, 32'h0);
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_scnt", 32'(stall_cnt), 32'd0);
      check("rst_fcnt", 32'(flush_cnt), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;

      // Plain flow
      drive(32'h2002_0005, 32'd4, 1'b1); push(32'h2002_0005, 32'd4, 1'b1); tick();
      check("flow1_stall", 32'(stall), 32'd0);
      drive(32'h0041_1820, 32'd8, 1'b1); push(32'h0041_1820, 32'd8, 1'b1); tick();
      check("flow2_stall", 32'(stall), 32'd0);

      // Load-use on rs of add $3,$2,$1
      ex_MemRead = 1'b1; ex_Rt = 5'd2;
      drive(32'h0062_1820, 32'd12, 1'b1);
      #1;
      check("lu_stall", 32'(stall), 32'd1);
      check("lu_bubble", 32'(bubble), 32'd1);
      push(32'h0041_1820, 32'd8, 1'b1); tick();
      ex_MemRead = 1'b0;
      #1;
      check("lu_release", 32'(stall), 32'd0);
      push(32'h0062_1820, 32'd12, 1'b1); tick();
      check("lu_scnt", 32'(stall_cnt), 32'd1);

      // No false stall: $0, and rt of an I-type that only reads rs
      ex_MemRead = 1'b1; ex_Rt = 5'd0;
      #1 check("zero_reg", 32'(stall), 32'd0);
      ex_Rt = 5'd2;
      #1 check("rtype_rt_hit", 32'(stall), 32'd1);
      ex_MemRead = 1'b0;
      drive(32'h2022_0001, 32'd16, 1'b1); push(32'h2022_0001, 32'd16, 1'b1); tick();
      ex_MemRead = 1'b1; ex_Rt = 5'd2;
      #1 check("addi_rt_ignored", 32'(stall), 32'd0);
      ex_Rt = 5'd1;
      #1 check("addi_rs_hit", 32'(stall), 32'd1);

      // Flush coincident with stall: squash wins, only flush is counted
      flush = 1'b1;
      drive(32'h1111_1111, 32'h40, 1'b1); push(32'h0, 32'h40, 1'b0); tick();
      check("fs_fcnt", 32'(flush_cnt), 32'd1);
      check("fs_scnt", 32'(stall_cnt), 32'd1);
      flush = 1'b0;
      #1 check("fs_invalid_nostall", 32'(stall), 32'd0);

      // sw reads rt
      ex_MemRead = 1'b0;
      drive(32'hAC22_0000, 32'h44, 1'b1); push(32'hAC22_0000, 32'h44, 1'b1); tick();
      ex_MemRead = 1'b1; ex_Rt = 5'd2;
      #1 check("sw_rt_hit", 32'(stall), 32'd1);
      ex_MemRead = 1'b0;

      // Bubble from fetch
      drive(32'h1234_5678, 32'h48, 1'b0); push(32'h0, 32'h48, 1'b0); tick();

      // Asynchronous reset mid-cycle with a load held in ID
      drive(32'h8C01_0004, 32'h4C, 1'b1); push(32'h8C01_0004, 32'h4C, 1'b1); tick();
      #2 Reset = 1'b1;
      #1;
      check("arst_inst", id_Inst, 32'h0);
      check("arst_pc", id_PC, 32'h0);
      check("arst_valid", 32'(id_valid), 32'd0);
      check("arst_stall", 32'(stall), 32'd0);
      check("arst_fcnt", 32'(flush_cnt), 32'd0);
      check("arst_scnt", 32'(stall_cnt), 32'd0);
      @(posedge CLK);
      #1 Reset = 1'b0;

      // Saturation of the stall counter
      drive(32'h0041_1820, 32'd4, 1'b1); push(32'h0041_1820, 32'd4, 1'b1); tick();
      ex_MemRead = 1'b1; ex_Rt = 5'd2;
      drive(32'h0, 32'd8, 1'b1);
      for (int i = 0; i < 65540; i++) @(posedge CLK);
      #1;
      check("sat_scnt", 32'(stall_cnt), 32'h0000_FFFF);
      check("sat_held_inst", id_Inst, 32'h0041_1820);
      @(posedge CLK);
      #1;
      check("sat_stays", 32'(stall_cnt), 32'h0000_FFFF);
      check("sat_fcnt", 32'(flush_cnt), 32'd0);
      ex_MemRead = 1'b0;

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- IF/ID pipeline register and load-use hazard unit for the 5-stage MIPS core.
- Sits directly downstream of the fetch stage. Captures fetched Inst/PC each cycle and presents them to decode.
- Raises stall back to the fetch stage on a load-use hazard and inserts a bubble toward ID/EX.
- Squashes the held instruction on a taken branch or jump, and keeps a saturating stall/flush performance count.

Parameters:
- WIDTH, 32, instruction and PC width.
- CNT_W, 16, width of each performance counter.
- NOP, 32'h0000_0000, instruction word loaded on reset, flush or bubble.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_Inst  in  WIDTH  instruction from the fetch stage.
- if_PC  in  WIDTH  PC from the fetch stage (address of the next sequential instruction, as Fetch produces it).
- if_valid  in  1  fetch output is meaningful this cycle; 0 inserts a bubble.
- flush  in  1  branch/jump resolved taken; kill the instruction in IF/ID.
- ex_MemRead  in  1  instruction in ID/EX is a load.
- ex_Rt  in  5  destination register of the ID/EX load.
- id_Inst  out  WIDTH  registered instruction to decode.
- id_PC  out  WIDTH  registered PC to decode.
- id_valid  out  1  id_Inst is a real instruction.
- stall  out  1  combinational; freeze PC and IF/ID. Drives IF_STAGE.stall.
- bubble  out  1  combinational; ID/EX must load control zeros this cycle (equals stall).
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset (async, any time, including mid-stall): id_Inst=NOP, id_PC=0, id_valid=0, stall_cnt=0, flush_cnt=0. stall and bubble therefore evaluate to 0.
- Decode fields used by the hazard logic: opcode=id_Inst[31:26], rs=id_Inst[25:21], rt=id_Inst[20:16].
- uses_rt=1 when opcode is 6'h00 (R-type), 6'h04 (beq), 6'h05 (bne) or 6'h2B (sw); otherwise 0.
- Hazard: stall = id_valid & ex_MemRead & (ex_Rt!=0) & ((ex_Rt==rs) | (uses_rt & ex_Rt==rt)).
- Stall is purely combinational, in the same cycle as the hazard. There is no registered delay.
- Register update priority per rising edge:
  - flush=1: load NOP, id_valid=0, id_PC=if_PC. Flush wins over stall.
  - else stall=1: hold id_Inst, id_PC and id_valid unchanged.
  - else: id_Inst = if_valid ? if_Inst : NOP; id_PC=if_PC; id_valid=if_valid.
- Latency: one cycle from IF output to id_* outputs.
- Load-use stall lasts exactly one cycle. The next cycle ID/EX holds the bubble (ex_MemRead=0), so stall drops.
- Back-to-back loads feeding each other yield one stall per dependent pair.
- Register $0 never causes a stall.
- Counters:
  - stall_cnt increments on each edge where stall=1 and flush=0.
  - flush_cnt increments on each edge where flush=1.
  - Both saturate at all-ones with no wrap.
- Simultaneous flush and stall: flush_cnt increments, stall_cnt does not, and the register is squashed.

Decomposition:
- Shared package mips_pkg holds the opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW) and the NOP word. The decode stage uses the same package.
- One sub-module: hazard_detect, the pure combinational stall equation. It is reused later when forwarding is added.
- The counters are inline; a sat_counter sub-module is optional.

Test Plan:
- Reset asserted mid-run with id_Inst=32'h8C01_0004: outputs go to 0/NOP and id_valid=0 immediately, without waiting for CLK; stall=0.
- Plain flow: feed if_Inst 32'h2002_0005 with PC 4, then 32'h0041_1820 with PC 8 → id_* follow one cycle later and stall stays 0 throughout.
- Load-use: ex_MemRead=1, ex_Rt=2, id_Inst=32'h0041_1820 (add $3,$2,$1) → stall=bubble=1 for one cycle and id_Inst held. With ex_MemRead=0 the next cycle, it advances; stall_cnt=1.
- No false stall: ex_Rt=0, or id_Inst=32'h2022_0001 (addi, rt not used) with ex_Rt=2 → stall=0.
- Flush and stall in the same cycle: hazard condition present plus flush=1 → id_Inst=NOP, id_valid=0; flush_cnt=1, stall_cnt unchanged.
- Saturation: force 65540 stall cycles → stall_cnt=16'hFFFF and stays there; if_valid=0 cycles load NOP with id_valid=0.
